// File: rtl/idu_queued_decoder.sv
// idu_queued_decoder
//   RV32I instruction queue of DEPTH entries feeding a registered decoder.
//   It sits between fetch and the CU so that a stall on one side does not
//   stall the other. Invalid encodings are not dropped: they come out as
//   op 63 with out_invalid set, so the CU can trap on them.
// Ports
//   soc_clk, IDU_reset       clock, asynchronous active-high reset
//   flush                    synchronous discard of queue and output register
//   in_valid/in_ready        fetch handshake; in_ready is registered (level < DEPTH)
//   in_instr, in_pc          instruction word and its PC
//   out_valid/out_ready      CU handshake; out_* stay stable while stalled
//   out_op, out_invalid      CU op code (63 = invalid) and illegal flag
//   out_rd/rs1/rs2/shamt     register fields and shift amount, 0 when unused
//   out_imm, out_pc          sign-extended immediate (0 when unused), PC
//   q_level                  queue occupancy
module idu_queued_decoder #(
  parameter int DEPTH         = 4,
  parameter bit STRICT_FUNCT7 = 1'b1,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic                       soc_clk,
  input  logic                       IDU_reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 out_op,
  output logic                       out_invalid,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_shamt,
  output logic [31:0]                out_imm,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_level
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_ONE  = 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [5:0]       OP_INV   = 6'd63;

  typedef enum logic [2:0] {FMT_NONE, FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R} fmt_e;

  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop, mem_we;

  logic             out_valid_q, out_valid_d, out_invalid_q, out_invalid_d;
  logic [5:0]       out_op_q, out_op_d;
  logic [4:0]       out_rd_q, out_rd_d, out_rs1_q, out_rs1_d;
  logic [4:0]       out_rs2_q, out_rs2_d, out_shamt_q, out_shamt_d;
  logic [31:0]      out_imm_q, out_imm_d, out_pc_q, out_pc_d;

  logic [31:0]      h;
  logic [2:0]       f3;
  logic [6:0]       f7, f7_exp;
  logic             f7_ok;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
  fmt_e             dec_fmt;
  logic [5:0]       dec_op;
  logic [4:0]       dec_rd, dec_rs1, dec_rs2, dec_shamt;
  logic [31:0]      dec_imm;

  // Queue control: pointers, level and the registered ready
  always_comb begin
    push     = in_valid && in_ready_q;
    pop      = (level_q != '0) && (!out_valid_q || out_ready);
    mem_we   = push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
    in_ready_d = (level_d < LVL_FULL);
  end

  // Storage carries no reset: the cleared level makes stale words unreachable.
  always_ff @(posedge soc_clk) begin
    if (mem_we) begin
      mem_instr_q[wr_ptr_q] <= in_instr;
      mem_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  // Decode of the queue head
  always_comb begin
    h      = mem_instr_q[rd_ptr_q];
    f3     = h[14:12];
    f7     = h[31:25];
    // Only SUB/SRA/SRAI (f3 0 or 5 with bit 30 set) may carry funct7 = 0x20.
    f7_exp = ((f3 == 3'd0 || f3 == 3'd5) && h[30]) ? 7'h20 : 7'h00;
    f7_ok  = !STRICT_FUNCT7 || (f7 == f7_exp);
    imm_i  = {{20{h[31]}}, h[31:20]};
    imm_s  = {{20{h[31]}}, h[31:25], h[11:7]};
    imm_b  = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
    imm_u  = {h[31:12], 12'h000};
    imm_j  = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
    dec_op  = OP_INV;
    dec_fmt = FMT_NONE;
    case (h[6:0])
      7'b0110111: begin dec_op = 6'd0; dec_fmt = FMT_U; end
      7'b0010111: begin dec_op = 6'd1; dec_fmt = FMT_U; end
      7'b1101111: begin dec_op = 6'd2; dec_fmt = FMT_J; end
      7'b1100111: begin dec_fmt = FMT_I; if (f3 == 3'd0) dec_op = 6'd3; end
      7'b1100011: begin
        dec_fmt = FMT_B;
        case (f3)
          3'd0: dec_op = 6'd4;  3'd1: dec_op = 6'd5;  3'd4: dec_op = 6'd6;
          3'd5: dec_op = 6'd7;  3'd6: dec_op = 6'd8;  3'd7: dec_op = 6'd9;
          default: dec_op = OP_INV;
        endcase
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        if (f3 <= 3'd2) dec_op = 6'd10 + {3'd0, f3};
      end
      7'b0000011: begin
        dec_fmt = FMT_I;
        case (f3)
          3'd0: dec_op = 6'd13;  3'd1: dec_op = 6'd14;  3'd2: dec_op = 6'd15;
          3'd4: dec_op = 6'd16;  3'd5: dec_op = 6'd17;
          default: dec_op = OP_INV;
        endcase
      end
      7'b0010011: begin
        dec_fmt = FMT_I;
        case (f3)
          3'd0: dec_op = 6'd18;  3'd2: dec_op = 6'd19;  3'd3: dec_op = 6'd20;
          3'd4: dec_op = 6'd21;  3'd6: dec_op = 6'd22;  3'd7: dec_op = 6'd23;
          3'd1: begin dec_fmt = FMT_SH; dec_op = f7_ok ? 6'd24 : OP_INV; end
          default: begin
            dec_fmt = FMT_SH;
            dec_op  = !f7_ok ? OP_INV : (h[30] ? 6'd26 : 6'd25);
          end
        endcase
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        case (f3)
          3'd0: dec_op = h[30] ? 6'd28 : 6'd27;
          3'd5: dec_op = h[30] ? 6'd34 : 6'd33;
          3'd6: dec_op = 6'd35;
          3'd7: dec_op = 6'd36;
          default: dec_op = 6'd28 + {3'd0, f3};
        endcase
        if (!f7_ok) dec_op = OP_INV;
      end
      7'b0001111: begin
        if (ENABLE_SYSTEM && f3 == 3'd0) dec_op = 6'd37;
        if (ENABLE_SYSTEM && f3 == 3'd1 && (!STRICT_FUNCT7 || h == 32'h0000100F)) dec_op = 6'd38;
      end
      7'b1110011: begin
        if (ENABLE_SYSTEM) begin
          if (STRICT_FUNCT7) begin
            if (h == 32'h00000073) dec_op = 6'd39;
            if (h == 32'h00100073) dec_op = 6'd40;
          end else if (f3 == 3'd0) begin
            dec_op = h[20] ? 6'd40 : 6'd39;
          end
        end
      end
      default: dec_op = OP_INV;
    endcase
    dec_rd    = '0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_shamt = '0;
    dec_imm   = '0;
    if (dec_op != OP_INV) begin
      case (dec_fmt)
        FMT_U:  begin dec_rd = h[11:7]; dec_imm = imm_u; end
        FMT_J:  begin dec_rd = h[11:7]; dec_imm = imm_j; end
        FMT_I:  begin dec_rd = h[11:7]; dec_rs1 = h[19:15]; dec_imm = imm_i; end
        FMT_SH: begin
          dec_rd = h[11:7]; dec_rs1 = h[19:15]; dec_imm = imm_i; dec_shamt = h[24:20];
        end
        FMT_S:  begin dec_rs1 = h[19:15]; dec_rs2 = h[24:20]; dec_imm = imm_s; end
        FMT_B:  begin dec_rs1 = h[19:15]; dec_rs2 = h[24:20]; dec_imm = imm_b; end
        FMT_R:  begin dec_rd = h[11:7]; dec_rs1 = h[19:15]; dec_rs2 = h[24:20]; end
        default: ;
      endcase
    end
  end

  // Output register: loads on pop, holds while stalled
  always_comb begin
    out_valid_d   = out_valid_q;
    out_op_d      = out_op_q;
    out_invalid_d = out_invalid_q;
    out_rd_d      = out_rd_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_shamt_d   = out_shamt_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d   = 1'b1;
      out_op_d      = dec_op;
      out_invalid_d = (dec_op == OP_INV);
      out_rd_d      = dec_rd;
      out_rs1_d     = dec_rs1;
      out_rs2_d     = dec_rs2;
      out_shamt_d   = dec_shamt;
      out_imm_d     = dec_imm;
      out_pc_d      = mem_pc_q[rd_ptr_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge soc_clk or posedge IDU_reset) begin
    if (IDU_reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_invalid_q <= 1'b0;
      out_rd_q      <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_shamt_q   <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_op_q      <= out_op_d;
      out_invalid_q <= out_invalid_d;
      out_rd_q      <= out_rd_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_shamt_q   <= out_shamt_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign q_level     = level_q;
  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_invalid = out_invalid_q;
  assign out_rd      = out_rd_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_shamt   = out_shamt_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
endmodule

// File: tb/tb_idu_queued_decoder.sv
// tb_idu_queued_decoder
//   Two instances share one input stream: A uses the default parameters
//   (strict funct7, system ops enabled), B relaxes funct7 checking and
//   disables system ops. Instructions are built from a mnemonic and random
//   fields, so each one's expected decode is known when it is encoded.
module tb_idu_queued_decoder;
  localparam int DEPTH = 4;

  logic        soc_clk = 1'b0;
  logic        IDU_reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_out_invalid;
  logic [5:0]  a_out_op;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2, a_out_shamt;
  logic [31:0] a_out_imm, a_out_pc;
  logic [2:0]  a_q_level;
  logic        b_in_ready, b_out_valid, b_out_invalid;
  logic [5:0]  b_out_op;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2, b_out_shamt;
  logic [31:0] b_out_imm, b_out_pc;
  logic [2:0]  b_q_level;

  always #5 soc_clk = ~soc_clk;

  idu_queued_decoder #(.DEPTH(DEPTH), .STRICT_FUNCT7(1'b1), .ENABLE_SYSTEM(1'b1)) u_a (
    .soc_clk(soc_clk), .IDU_reset(IDU_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_op(a_out_op),
    .out_invalid(a_out_invalid), .out_rd(a_out_rd), .out_rs1(a_out_rs1),
    .out_rs2(a_out_rs2), .out_shamt(a_out_shamt), .out_imm(a_out_imm),
    .out_pc(a_out_pc), .q_level(a_q_level));

  idu_queued_decoder #(.DEPTH(DEPTH), .STRICT_FUNCT7(1'b0), .ENABLE_SYSTEM(1'b0)) u_b (
    .soc_clk(soc_clk), .IDU_reset(IDU_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_op(b_out_op),
    .out_invalid(b_out_invalid), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_shamt(b_out_shamt), .out_imm(b_out_imm),
    .out_pc(b_out_pc), .q_level(b_q_level));

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] imm;
  } dec_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    dec_t        e1;
    dec_t        e2;
  } item_t;

  item_t       mq[$];
  item_t       mout, cur;
  bit          mov, accepted;
  int          n_cmp, n_err;
  logic [31:0] pc_ctr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic dec_t dd(input int op, input int rd, input int rs1, input int rs2,
                              input int sh, input logic [31:0] imm);
    dec_t d;
    d.op = 6'(op); d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.shamt = 5'(sh);
    d.imm = imm;
    return d;
  endfunction

  function automatic dec_t dinv();
    dec_t d;
    d = '0;
    d.op = 6'd63;
    return d;
  endfunction

  function automatic item_t mk(input logic [31:0] ins, input dec_t e1, input dec_t e2);
    item_t it;
    it.instr = ins; it.pc = pc_ctr; it.e1 = e1; it.e2 = e2;
    pc_ctr = pc_ctr + 32'd4;
    return it;
  endfunction

  // Encode mnemonic k (CU op code) with random fields.
  function automatic item_t gen_valid(input int k);
    logic [31:0] r, ins;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    logic [20:0] j;
    logic [12:0] b;
    dec_t        d;
    r = $urandom; rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    d = '0; d.op = 6'(k); ins = '0; f3 = '0; f7 = '0;
    j = {r[20:1], 1'b0}; b = {r[12:1], 1'b0};
    if (k <= 1) begin
      opc = (k == 0) ? 7'b0110111 : 7'b0010111;
      ins = {r[31:12], rd, opc}; d.rd = rd; d.imm = {r[31:12], 12'h000};
    end else if (k == 2) begin
      ins = {j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111};
      d.rd = rd; d.imm = {{11{j[20]}}, j};
    end else if (k >= 4 && k <= 9) begin
      case (k) 4: f3 = 3'd0; 5: f3 = 3'd1; 6: f3 = 3'd4; 7: f3 = 3'd5; 8: f3 = 3'd6; default: f3 = 3'd7; endcase
      ins = {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
      d.rs1 = rs1; d.rs2 = rs2; d.imm = {{19{b[12]}}, b};
    end else if (k >= 10 && k <= 12) begin
      f3 = 3'(k - 10);
      ins = {r[11:5], rs2, rs1, f3, r[4:0], 7'b0100011};
      d.rs1 = rs1; d.rs2 = rs2; d.imm = sx12(r[11:0]);
    end else if (k == 3 || (k >= 13 && k <= 23)) begin
      case (k)
        3, 13, 18: f3 = 3'd0;  14: f3 = 3'd1;  15, 19: f3 = 3'd2;  20: f3 = 3'd3;
        16, 21: f3 = 3'd4;  17: f3 = 3'd5;  22: f3 = 3'd6;  default: f3 = 3'd7;
      endcase
      opc = (k == 3) ? 7'b1100111 : (k <= 17) ? 7'b0000011 : 7'b0010011;
      ins = {r[11:0], rs1, f3, rd, opc};
      d.rd = rd; d.rs1 = rs1; d.imm = sx12(r[11:0]);
    end else if (k >= 24 && k <= 26) begin
      f3 = (k == 24) ? 3'd1 : 3'd5;
      f7 = (k == 26) ? 7'h20 : 7'h00;
      ins = {f7, rs2, rs1, f3, rd, 7'b0010011};
      d.rd = rd; d.rs1 = rs1; d.shamt = rs2; d.imm = sx12({f7, rs2});
    end else if (k >= 27 && k <= 36) begin
      case (k)
        27, 28: f3 = 3'd0;  29: f3 = 3'd1;  30: f3 = 3'd2;  31: f3 = 3'd3;
        32: f3 = 3'd4;  33, 34: f3 = 3'd5;  35: f3 = 3'd6;  default: f3 = 3'd7;
      endcase
      f7 = (k == 28 || k == 34) ? 7'h20 : 7'h00;
      ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
      d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    end else if (k == 37) ins = {r[31:20], 5'd0, 3'd0, 5'd0, 7'b0001111};
    else if (k == 38)     ins = 32'h0000100F;
    else if (k == 39)     ins = 32'h00000073;
    else                  ins = 32'h00100073;
    return mk(ins, d, (k >= 37) ? dinv() : d);
  endfunction

  // Encodings that strict decoding rejects; B sometimes still decodes them.
  function automatic item_t gen_invalid();
    logic [31:0] r, ins;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    dec_t        d2;
    int          c;
    r = $urandom; rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    c = int'($urandom_range(0, 5));
    d2 = dinv(); f7 = r[6:0] | 7'h01; f3 = 3'($urandom); ins = '0;
    case (c)
      0: begin
        ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
        case (f3)
          3'd0: d2.op = f7[5] ? 6'd28 : 6'd27;
          3'd5: d2.op = f7[5] ? 6'd34 : 6'd33;
          3'd6: d2.op = 6'd35;
          3'd7: d2.op = 6'd36;
          default: d2.op = 6'd28 + {3'd0, f3};
        endcase
        d2.rd = rd; d2.rs1 = rs1; d2.rs2 = rs2;
      end
      1: begin
        f3 = r[31] ? 3'd1 : 3'd5;
        ins = {f7, rs2, rs1, f3, rd, 7'b0010011};
        d2.op = (f3 == 3'd1) ? 6'd24 : (f7[5] ? 6'd26 : 6'd25);
        d2.rd = rd; d2.rs1 = rs1; d2.shamt = rs2; d2.imm = sx12({f7, rs2});
      end
      2: begin
        case (r[2:0])
          3'd0: opc = 7'b0000000;  3'd1: opc = 7'b1111111;  3'd2: opc = 7'b0101111;
          3'd3: opc = 7'b1010011;  3'd4: opc = 7'b0000111;  3'd5: opc = 7'b1011011;
          3'd6: opc = 7'b0100111;  default: opc = 7'b1110111;
        endcase
        ins = {r[31:7], opc};
      end
      3: begin
        case (r[1:0])
          2'd0: begin opc = 7'b1100011; f3 = r[8] ? 3'd2 : 3'd3; end
          2'd1: begin opc = 7'b0000011; f3 = (r[9:8] == 2'd0) ? 3'd3 : (r[9:8] == 2'd1) ? 3'd6 : 3'd7; end
          2'd2: begin opc = 7'b0100011; f3 = 3'd3 + {1'b0, r[9:8]}; end
          default: begin opc = 7'b1100111; f3 = (r[10:8] == 3'd0) ? 3'd1 : r[10:8]; end
        endcase
        ins = {r[31:20], rs1, f3, rd, opc};
      end
      4: ins = {11'd0, r[20], 5'd0, 3'd0, rd | 5'd1, 7'b1110011};
      default: begin
        if (r[0]) ins = {12'd0, 5'd0, 3'd1, rd | 5'd1, 7'b0001111};
        else begin
          f3 = (r[3:1] < 3'd2) ? 3'd2 : r[3:1];
          ins = {r[31:20], 5'd0, f3, 5'd0, 7'b0001111};
        end
      end
    endcase
    return mk(ins, dinv(), d2);
  endfunction

  task automatic set_item(input item_t it);
    cur = it; in_instr = it.instr; in_pc = it.pc;
  endtask

  task automatic drive_new();
    if ($urandom_range(0, 3) == 0) set_item(gen_invalid());
    else set_item(gen_valid(int'($urandom_range(0, 40))));
  endtask

  task automatic chk_out(input string who, input logic [5:0] op, input logic inv,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] sh, input logic [31:0] imm, input logic [31:0] pc,
                         input dec_t e, input logic [31:0] epc);
    chk({who, "_op"},    32'(op),  32'(e.op));
    chk({who, "_inv"},   32'(inv), 32'(e.op == 6'd63));
    chk({who, "_rd"},    32'(rd),  32'(e.rd));
    chk({who, "_rs1"},   32'(rs1), 32'(e.rs1));
    chk({who, "_rs2"},   32'(rs2), 32'(e.rs2));
    chk({who, "_shamt"}, 32'(sh),  32'(e.shamt));
    chk({who, "_imm"},   imm, e.imm);
    chk({who, "_pc"},    pc, epc);
  endtask

  task automatic check_state();
    chk("a_out_valid", 32'(a_out_valid), 32'(mov));
    chk("b_out_valid", 32'(b_out_valid), 32'(mov));
    chk("a_q_level",   32'(a_q_level),   32'(mq.size()));
    chk("b_q_level",   32'(b_q_level),   32'(mq.size()));
    chk("a_in_ready",  32'(a_in_ready),  32'(mq.size() < DEPTH));
    chk("b_in_ready",  32'(b_in_ready),  32'(mq.size() < DEPTH));
    if (mov) begin
      chk_out("a", a_out_op, a_out_invalid, a_out_rd, a_out_rs1, a_out_rs2, a_out_shamt,
              a_out_imm, a_out_pc, mout.e1, mout.pc);
      chk_out("b", b_out_op, b_out_invalid, b_out_rd, b_out_rs1, b_out_rs2, b_out_shamt,
              b_out_imm, b_out_pc, mout.e2, mout.pc);
    end
  endtask

  task automatic check_reset(input string tag);
    dec_t z;
    z = '0;
    chk({tag, "_a_valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_b_valid"}, 32'(b_out_valid), 32'd0);
    chk({tag, "_a_level"}, 32'(a_q_level), 32'd0);
    chk({tag, "_a_ready"}, 32'(a_in_ready), 32'd1);
    chk({tag, "_b_ready"}, 32'(b_in_ready), 32'd1);
    chk_out({tag, "_a"}, a_out_op, a_out_invalid, a_out_rd, a_out_rs1, a_out_rs2,
            a_out_shamt, a_out_imm, a_out_pc, z, 32'd0);
    chk_out({tag, "_b"}, b_out_op, b_out_invalid, b_out_rd, b_out_rs1, b_out_rs2,
            b_out_shamt, b_out_imm, b_out_pc, z, 32'd0);
  endtask

  // One clock: update the reference queue from the inputs seen at the edge, then compare.
  task automatic cycle();
    bit pop, push;
    @(posedge soc_clk);
    accepted = 1'b0;
    if (flush) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && (!mov || out_ready);
      push = in_valid && (mq.size() < DEPTH);
      if (pop) begin
        mout = mq.pop_front();
        mov  = 1'b1;
      end else if (mov && out_ready) begin
        mov = 1'b0;
      end
      if (push) mq.push_back(cur);
      accepted = push;
    end
    #1;
    check_state();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pc_ctr = 32'h0000_1000; mov = 1'b0; accepted = 1'b0;
    IDU_reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; cur = '0; mout = '0;
    repeat (2) @(posedge soc_clk);
    #1 check_reset("reset");
    @(negedge soc_clk) IDU_reset = 1'b0;

    // addi x1,x0,5: visible one edge after the push edge
    set_item(mk(32'h00500093, dd(18, 1, 0, 0, 0, 32'd5), dd(18, 1, 0, 0, 0, 32'd5)));
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("addi_valid", 32'(a_out_valid), 32'd1);
    chk("addi_op",    32'(a_out_op),    32'd18);
    chk("addi_rd",    32'(a_out_rd),    32'd1);
    chk("addi_imm",   a_out_imm,        32'd5);
    cycle();

    // Fill with the CU stalled, then drain in order
    out_ready = 1'b0; in_valid = 1'b1;
    drive_new();
    for (int i = 0; i < DEPTH + 4; i++) begin
      cycle();
      if (accepted) drive_new();
    end
    chk("full_ready", 32'(a_in_ready), 32'd0);
    chk("full_level", 32'(a_q_level),  32'(DEPTH));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 3) cycle();

    // Directed decodes: beq -4, sub, add with funct7=1, ecall
    out_ready = 1'b1; in_valid = 1'b1;
    set_item(mk(32'hFE000EE3, dd(4, 0, 0, 0, 0, 32'hFFFFFFFC), dd(4, 0, 0, 0, 0, 32'hFFFFFFFC)));
    cycle();
    set_item(mk(32'h40000033, dd(28, 0, 0, 0, 0, 32'd0), dd(28, 0, 0, 0, 0, 32'd0)));
    cycle();
    set_item(mk(32'h02000033, dinv(), dd(27, 0, 0, 0, 0, 32'd0)));
    cycle();
    set_item(mk(32'h00000073, dd(39, 0, 0, 0, 0, 32'd0), dinv()));
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Flush with three queued and a push in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_new();
      cycle();
    end
    chk("preflush_level", 32'(a_q_level), 32'd3);
    drive_new();
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", 32'(a_q_level),   32'd0);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    drive_new();
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Back-to-back stream across pointer wrap
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      drive_new();
      cycle();
      chk("stream_ready", 32'(a_in_ready), 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    // Random traffic with occasional flush
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      drive_new();
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      drive_new();
      cycle();
    end
    #2 IDU_reset = 1'b1;
    #1 check_reset("midrst");
    mq.delete(); mov = 1'b0;
    in_valid = 1'b0;
    @(negedge soc_clk) IDU_reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      drive_new();
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
